// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element table for the SRAM self-test engine.
// Element ops: direction, read/write data polarity, which ops are present.
package sram_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;

    typedef struct packed {
        logic down;
        logic rd_val;
        logic wr_val;
        logic has_rd;
        logic has_wr;
    } elem_op_t;

    function automatic elem_op_t elem_op(input logic [2:0] e);
        elem_op_t op;
        op = '0;
        case (e)
            E0: op = '{down: 1'b0, rd_val: 1'b0, wr_val: 1'b0,
                       has_rd: 1'b0, has_wr: 1'b1};
            E1: op = '{down: 1'b0, rd_val: 1'b0, wr_val: 1'b1,
                       has_rd: 1'b1, has_wr: 1'b1};
            E2: op = '{down: 1'b0, rd_val: 1'b1, wr_val: 1'b0,
                       has_rd: 1'b1, has_wr: 1'b1};
            E3: op = '{down: 1'b1, rd_val: 1'b0, wr_val: 1'b1,
                       has_rd: 1'b1, has_wr: 1'b1};
            E4: op = '{down: 1'b1, rd_val: 1'b1, wr_val: 1'b0,
                       has_rd: 1'b1, has_wr: 1'b1};
            E5: op = '{down: 1'b0, rd_val: 1'b0, wr_val: 1'b0,
                       has_rd: 1'b1, has_wr: 1'b0};
            default: op = '0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter for the March engine.
// last flags the terminal address of the current direction.
module sram_bist_addr_gen #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    input  logic                  down,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    // Load the element start address or step one position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= down ? addr - 1'b1 : addr + 1'b1;
        end
    end

    assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March C- self-test initiator for the multibank SRAM wrapper.
// Drives csb/web/addr/din, checks dout, captures the first failure.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  csb,
    output logic                  web,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_syndr
);

    localparam int WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WW-1:0] WLAST = WW'(READ_LATENCY - 1);

    state_t          state, state_d;
    logic [2:0]      elem, elem_d, nel;
    logic            rd, rd_d;
    logic [WW-1:0]   wcnt, wcnt_d;
    logic            csb_d, web_d;
    logic [DATA_WIDTH-1:0] din_d;
    logic            ag_load, ag_load_down, ag_step, last;
    logic            issue, adv;
    elem_op_t        op, nop;
    logic            cmp, mism, accept;
    logic [DATA_WIDTH-1:0] expv;
    logic [CNT_WIDTH-1:0]  cnt_nxt;

    sram_bist_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ag_load),
        .load_down(ag_load_down),
        .step     (ag_step),
        .down     (op.down),
        .addr     (addr),
        .last     (last)
    );

    assign op      = elem_op(elem);
    assign accept  = (state == IDLE) && start;
    assign cmp     = (state == WAIT) && (wcnt == WLAST);
    assign expv    = {DATA_WIDTH{op.rd_val}};
    assign mism    = cmp && (dout != expv);
    assign cnt_nxt = (mism && (fail_count != '1)) ?
                     fail_count + 1'b1 : fail_count;

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            elem  <= E0;
            rd    <= 1'b0;
            wcnt  <= '0;
        end else begin
            state <= state_d;
            elem  <= elem_d;
            rd    <= rd_d;
            wcnt  <= wcnt_d;
        end
    end

    // Next state and next-cycle memory port values.
    always_comb begin
        state_d = state;
        elem_d  = elem;
        rd_d    = rd;
        wcnt_d  = wcnt;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        din_d   = '0;
        ag_load = 1'b0;
        ag_step = 1'b0;
        issue   = 1'b0;
        adv     = 1'b0;
        nel     = elem;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nel     = E0;
                    elem_d  = E0;
                    ag_load = 1'b1;
                    issue   = 1'b1;
                end
            end
            ISSUE: begin
                if (rd) begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end else begin
                    adv = 1'b1;
                end
            end
            WAIT: begin
                if (wcnt == WLAST) begin
                    if (op.has_wr) begin
                        state_d = ISSUE;
                        rd_d    = 1'b0;
                        csb_d   = 1'b0;
                        web_d   = 1'b0;
                        din_d   = {DATA_WIDTH{op.wr_val}};
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt + 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (adv) begin
            if (!last) begin
                ag_step = 1'b1;
                issue   = 1'b1;
            end else if (elem == E5) begin
                state_d = FINISH;
            end else begin
                nel     = elem + 3'd1;
                elem_d  = nel;
                ag_load = 1'b1;
                issue   = 1'b1;
            end
        end
        nop          = elem_op(nel);
        ag_load_down = nop.down;
        if (issue) begin
            state_d = ISSUE;
            rd_d    = nop.has_rd;
            csb_d   = 1'b0;
            web_d   = nop.has_rd;
            din_d   = nop.has_rd ? '0 : {DATA_WIDTH{nop.wr_val}};
        end
    end

    // Registered port drive and run status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb  <= 1'b1;
            web  <= 1'b1;
            din  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            csb  <= csb_d;
            web  <= web_d;
            din  <= din_d;
            busy <= (state_d == ISSUE) || (state_d == WAIT);
            done <= (state_d == FINISH);
        end
    end

    // Mismatch counting, first-failure capture and verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass       <= 1'b0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_syndr <= '0;
        end else if (accept) begin
            pass       <= 1'b0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_syndr <= '0;
        end else begin
            if (mism) begin
                fail_count <= cnt_nxt;
                if (fail_count == '0) begin
                    fail_addr  <= addr;
                    fail_elem  <= elem;
                    fail_syndr <= dout ^ expv;
                end
            end
            if (state_d == FINISH) begin
                pass <= (cnt_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist: four engine instances, each with
// a behavioural SRAM that can inject stuck-at, coupling or all-ones faults.
module tb_sram_march_bist;

    localparam int RLS [4] = '{2, 2, 1, 3};
    localparam int CWS [4] = '{16, 2, 16, 16};
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic clk;
    logic rst_n;
    logic [3:0] start_v;
    int fmode;
    bit trace_on;

    logic [3:0]  csb_v, web_v, busy_v, done_v, pass_v;
    logic [1:0]  addr_v  [4];
    logic [31:0] din_v   [4];
    logic [31:0] syn_v   [4];
    logic [15:0] fcnt_v  [4];
    logic [1:0]  faddr_v [4];
    logic [2:0]  felem_v [4];

    int n_chk;
    int n_fail;
    logic [4:0] trace_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gi
        localparam int RL = RLS[g];
        localparam int CW = CWS[g];
        logic [31:0]   dout;
        logic [CW-1:0] fcnt;
        logic [31:0]   mem  [4];
        logic [31:0]   pipe [RL];

        sram_march_bist #(
            .DATA_WIDTH(32),
            .ADDR_WIDTH(2),
            .READ_LATENCY(RL),
            .CNT_WIDTH(CW)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .start(start_v[g]),
            .dout(dout),
            .csb(csb_v[g]),
            .web(web_v[g]),
            .addr(addr_v[g]),
            .din(din_v[g]),
            .busy(busy_v[g]),
            .done(done_v[g]),
            .pass(pass_v[g]),
            .fail_count(fcnt),
            .fail_addr(faddr_v[g]),
            .fail_elem(felem_v[g]),
            .fail_syndr(syn_v[g])
        );

        assign fcnt_v[g] = 16'(fcnt);
        assign dout = pipe[RL-1];

        always @(posedge clk) begin
            if (!csb_v[g] && !web_v[g]) begin
                mem[addr_v[g]] <= din_v[g];
                if (fmode == 2 && addr_v[g] == 2'd1 && din_v[g] == ONES)
                    mem[0] <= ONES;
            end
            if (!csb_v[g] && web_v[g])
                pipe[0] <= (fmode == 3) ? ONES :
                           (mem[addr_v[g]] |
                            ((fmode == 1 && addr_v[g] == 2'd2) ?
                             32'h20 : 32'h0));
            else
                pipe[0] <= 32'hDEAD_BEEF;
            for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
        end
    end

    always @(negedge clk) begin
        if (trace_on && !csb_v[0])
            trace_q.push_back({web_v[0], addr_v[0], din_v[0] == ONES,
                               din_v[0] != 32'h0 && din_v[0] != ONES});
    end

    task automatic start_pulse(input int i);
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int cyc, output bit ok);
        cyc = 0;
        ok = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            if (done_v[i]) ok = 1'b1;
            else begin
                if (busy_v[i]) cyc++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start_v = '0;
        fmode = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if ({csb_v[i], web_v[i], busy_v[i], done_v[i], pass_v[i]}
                !== 5'b11000) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: got %b want 11000", i,
                         {csb_v[i], web_v[i], busy_v[i], done_v[i],
                          pass_v[i]});
            end
            n_chk++;
            if ({addr_v[i], din_v[i]} !== 34'h0) begin
                n_fail++;
                $display("FAIL reset_port[%0d]: addr %h din %h want 0",
                         i, addr_v[i], din_v[i]);
            end
            n_chk++;
            if ({fcnt_v[i], faddr_v[i], felem_v[i], syn_v[i]} !== 53'h0)
            begin
                n_fail++;
                $display("FAIL reset_fail[%0d]: cnt %h addr %h elem %h syn %h want 0",
                         i, fcnt_v[i], faddr_v[i], felem_v[i], syn_v[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean;
        int cyc;
        bit ok;
        logic [4:0] exp_q [$];
        for (int e = 0; e < 6; e++) begin
            bit dn, hr, hw, wv;
            dn = (e == 3 || e == 4);
            hr = (e != 0);
            hw = (e != 5);
            wv = (e == 1 || e == 3);
            for (int j = 0; j < 4; j++) begin
                logic [1:0] a;
                a = dn ? 2'(3 - j) : 2'(j);
                if (hr) exp_q.push_back({1'b1, a, 1'b0, 1'b0});
                if (hw) exp_q.push_back({1'b0, a, wv, 1'b0});
            end
        end
        fmode = 0;
        trace_q.delete();
        trace_on = 1'b1;
        start_pulse(0);
        wait_done(0, cyc, ok);
        trace_on = 1'b0;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL clean_done: no done within bound");
        end
        n_chk++;
        if (cyc != 80) begin
            n_fail++;
            $display("FAIL clean_cycles: got %0d want 80", cyc);
        end
        n_chk++;
        if (pass_v[0] !== 1'b1 || fcnt_v[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL clean_pass: pass %b cnt %0d want 1/0",
                     pass_v[0], fcnt_v[0]);
        end
        n_chk++;
        if (trace_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL trace_len: got %0d want %0d", trace_q.size(),
                     exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_chk++;
                if (trace_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL trace[%0d]: got %b want %b", k,
                             trace_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_stuck;
        int cyc;
        bit ok;
        fmode = 1;
        start_pulse(0);
        wait_done(0, cyc, ok);
        n_chk++;
        if (!ok || pass_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_pass: done %b pass %b want 1/0", ok,
                     pass_v[0]);
        end
        n_chk++;
        if ({faddr_v[0], felem_v[0]} !== {2'd2, 3'd1}) begin
            n_fail++;
            $display("FAIL stuck_loc: addr %0d elem %0d want 2/1",
                     faddr_v[0], felem_v[0]);
        end
        n_chk++;
        if (syn_v[0] !== 32'h20) begin
            n_fail++;
            $display("FAIL stuck_syndr: got %h want 00000020", syn_v[0]);
        end
        n_chk++;
        if (fcnt_v[0] !== 16'd3) begin
            n_fail++;
            $display("FAIL stuck_count: got %0d want 3", fcnt_v[0]);
        end
        fmode = 0;
    endtask

    task automatic test_coupling;
        int cyc;
        bit ok;
        fmode = 2;
        start_pulse(0);
        n_chk++;
        if ({fcnt_v[0], felem_v[0], pass_v[0]} !== 20'h0) begin
            n_fail++;
            $display("FAIL restart_clear: cnt %0d elem %0d pass %b want 0",
                     fcnt_v[0], felem_v[0], pass_v[0]);
        end
        wait_done(0, cyc, ok);
        n_chk++;
        if (!ok || pass_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL cpl_pass: done %b pass %b want 1/0", ok,
                     pass_v[0]);
        end
        n_chk++;
        if ({faddr_v[0], felem_v[0]} !== {2'd0, 3'd3}) begin
            n_fail++;
            $display("FAIL cpl_loc: addr %0d elem %0d want 0/3",
                     faddr_v[0], felem_v[0]);
        end
        n_chk++;
        if (fcnt_v[0] !== 16'd1 || syn_v[0] !== ONES) begin
            n_fail++;
            $display("FAIL cpl_count: cnt %0d syn %h want 1/ffffffff",
                     fcnt_v[0], syn_v[0]);
        end
        fmode = 0;
    endtask

    task automatic test_saturate;
        int cyc;
        bit ok;
        fmode = 3;
        start_pulse(1);
        wait_done(1, cyc, ok);
        n_chk++;
        if (!ok || fcnt_v[1] !== 16'd3 || pass_v[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_count: done %b cnt %0d pass %b want 1/3/0",
                     ok, fcnt_v[1], pass_v[1]);
        end
        n_chk++;
        if ({faddr_v[1], felem_v[1]} !== {2'd0, 3'd1}) begin
            n_fail++;
            $display("FAIL sat_loc: addr %0d elem %0d want 0/1",
                     faddr_v[1], felem_v[1]);
        end
        n_chk++;
        if (syn_v[1] !== ONES) begin
            n_fail++;
            $display("FAIL sat_syndr: got %h want ffffffff", syn_v[1]);
        end
        fmode = 0;
    endtask

    task automatic test_abort;
        int cyc;
        int bad;
        bit ok;
        start_pulse(0);
        repeat (10) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n_chk++;
        if ({busy_v[0], web_v[0], addr_v[0]} !== {1'b1, 1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL restart_ignored: busy %b web %b addr %0d want 1/0/1",
                     busy_v[0], web_v[0], addr_v[0]);
        end
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({csb_v[0], busy_v[0], done_v[0], addr_v[0]} !== 5'b10000) begin
            n_fail++;
            $display("FAIL abort_state: csb %b busy %b done %b addr %0d want 1/0/0/0",
                     csb_v[0], busy_v[0], done_v[0], addr_v[0]);
        end
        rst_n = 1'b1;
        bad = 0;
        for (int t = 0; t < 120; t++) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
        end
        start_pulse(0);
        wait_done(0, cyc, ok);
        n_chk++;
        if (!ok || cyc != 80 || pass_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_rerun: done %b cycles %0d pass %b want 1/80/1",
                     ok, cyc, pass_v[0]);
        end
    endtask

    task automatic test_latency;
        int cyc;
        bit ok;
        int want [4];
        want = '{0, 0, 60, 100};
        for (int i = 2; i < 4; i++) begin
            start_pulse(i);
            wait_done(i, cyc, ok);
            n_chk++;
            if (!ok || cyc != want[i]) begin
                n_fail++;
                $display("FAIL lat_cycles[%0d]: done %b got %0d want %0d",
                         i, ok, cyc, want[i]);
            end
            n_chk++;
            if (pass_v[i] !== 1'b1 || fcnt_v[i] !== 16'd0) begin
                n_fail++;
                $display("FAIL lat_pass[%0d]: pass %b cnt %0d want 1/0",
                         i, pass_v[i], fcnt_v[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit ok;
        start_pulse(0);
        wait_done(0, cyc, ok);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        n_chk++;
        if (!ok || busy_v[0] !== 1'b0 || pass_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL finish_drop: done %b busy %b pass %b want 1/0/1",
                     ok, busy_v[0], pass_v[0]);
        end
        start_pulse(0);
        n_chk++;
        if (busy_v[0] !== 1'b1 || pass_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_accept: busy %b pass %b want 1/0",
                     busy_v[0], pass_v[0]);
        end
        wait_done(0, cyc, ok);
        n_chk++;
        if (!ok || cyc != 80 || pass_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_run: done %b cycles %0d pass %b want 1/80/1",
                     ok, cyc, pass_v[0]);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        trace_on = 1'b0;
        test_reset();
        test_clean();
        test_stuck();
        test_coupling();
        test_saturate();
        test_abort();
        test_latency();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
